// File: rtl/systolic_feeder.sv
// Operand skew/feed stage for an N x N systolic MAC array: buffers one A tile and
// one B tile, then streams them diagonally into the array edges with zero padding.
module systolic_feeder #(
  parameter int data_size = 8,
  parameter int N         = 4,
  parameter int IDX_W     = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [IDX_W-1:0]       wr_row,
  input  logic [IDX_W-1:0]       wr_col,
  input  logic [data_size-1:0]   wr_data,
  input  logic                   start,
  output logic [N*data_size-1:0] a_out,
  output logic [N*data_size-1:0] b_out,
  output logic                   array_clr,
  output logic                   busy,
  output logic                   done
);

  localparam int STEP_W = $clog2(2 * N);
  localparam logic [STEP_W-1:0] STREAM_LAST = STEP_W'(2 * N - 2);
  localparam logic [STEP_W-1:0] DRAIN_LAST  = STEP_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;

  logic [data_size-1:0]   a_buf_q [N][N];
  logic [data_size-1:0]   a_buf_d [N][N];
  logic [data_size-1:0]   b_buf_q [N][N];
  logic [data_size-1:0]   b_buf_d [N][N];

  logic [N*data_size-1:0] a_out_q, a_out_d;
  logic [N*data_size-1:0] b_out_q, b_out_d;
  logic                   array_clr_q, array_clr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        step_d = '0;
        if (start) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        step_d  = '0;
      end
      STREAM: begin
        if (step_q == STREAM_LAST) begin
          state_d = DRAIN;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DRAIN: begin
        if (step_q == DRAIN_LAST) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
      end
    endcase
  end

  // The tiles are frozen while busy so a pass always sees a consistent operand set.
  always_comb begin
    a_buf_d = a_buf_q;
    b_buf_d = b_buf_q;
    if (wr_en && !busy_q && (int'(wr_row) < N) && (int'(wr_col) < N)) begin
      if (wr_sel) begin
        b_buf_d[wr_row][wr_col] = wr_data;
      end else begin
        a_buf_d[wr_row][wr_col] = wr_data;
      end
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    int k;
    k           = 0;
    a_out_d     = '0;
    b_out_d     = '0;
    array_clr_d = (state_d == CLEAR);
    busy_d      = (state_d == CLEAR) || (state_d == STREAM) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    if (state_d == STREAM) begin
      for (int i = 0; i < N; i++) begin
        k = int'(step_d) - i;
        if ((k >= 0) && (k < N)) begin
          a_out_d[i*data_size +: data_size] = a_buf_q[i][k[IDX_W-1:0]];
          b_out_d[i*data_size +: data_size] = b_buf_q[k[IDX_W-1:0]][i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      array_clr_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_buf_q[i][j] <= '0;
          b_buf_q[i][j] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      array_clr_q <= array_clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_buf_q     <= a_buf_d;
      b_buf_q     <= b_buf_d;
    end
  end

  assign a_out     = a_out_q;
  assign b_out     = b_out_q;
  assign array_clr = array_clr_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus queues per-cycle expectations and
// a negedge monitor compares them, including a behavioural MAC array on the outputs.
module tb_systolic_feeder;

  localparam int D  = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W  = N * D;
  localparam int PASS_LEN = 3 * N + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          wr_sel;
  logic [IW-1:0] wr_row;
  logic [IW-1:0] wr_col;
  logic [D-1:0]  wr_data;
  logic          start;
  logic [W-1:0]  a_out;
  logic [W-1:0]  b_out;
  logic          array_clr;
  logic          busy;
  logic          done;

  systolic_feeder #(.data_size(D), .N(N), .IDX_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .a_out     (a_out),
    .b_out     (b_out),
    .array_clr (array_clr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int           tag;
    int           cyc;
    int           rel;
    int           kind;
    int           idx;
    int           val;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   am[N][N];
  int   bm[N][N];
  int   cexp[N][N];

  // Behavioural output-stationary MAC array fed by the DUT, cleared by array_clr.
  logic [D-1:0] ar[N][N];
  logic [D-1:0] br[N][N];
  int           accm[N][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (array_clr) begin
          ar[i][j]   <= '0;
          br[i][j]   <= '0;
          accm[i][j] <= 0;
        end else begin
          ar[i][j]   <= (j == 0) ? a_out[i*D +: D] : ar[i][j-1];
          br[i][j]   <= (i == 0) ? b_out[j*D +: D] : br[i-1][j];
          accm[i][j] <= accm[i][j]
                        + int'((j == 0) ? a_out[i*D +: D] : ar[i][j-1])
                        * int'((i == 0) ? b_out[j*D +: D] : br[i-1][j]);
        end
      end
    end
  end

  task automatic checkOutput(input int tag, input int kind, input int rel,
                             input logic [127:0] got, input logic [127:0] expv);
    total++;
    if (got === expv) begin
      passed++;
    end else begin
      $display("[TB] FAIL test%0d kind%0d cycle%0d got=%h expected=%h",
               tag, kind, rel, got, expv);
    end
  endtask

  always @(negedge clk) begin
    for (int q = sb.size() - 1; q >= 0; q--) begin
      if (sb[q].cyc <= cyc) begin
        mon_e = sb[q];
        if (mon_e.cyc < cyc) begin
          checkOutput(mon_e.tag, 9, mon_e.rel, 128'(cyc), 128'(mon_e.cyc));
        end else begin
          case (mon_e.kind)
            0: checkOutput(mon_e.tag, 0, mon_e.rel,
                           128'({a_out, b_out, array_clr, busy, done}),
                           128'({mon_e.a, mon_e.b, mon_e.clr, mon_e.busy, mon_e.done}));
            1: checkOutput(mon_e.tag, 1, mon_e.idx,
                           128'(accm[mon_e.idx / N][mon_e.idx % N]), 128'(mon_e.val));
            default: checkOutput(mon_e.tag, 2, mon_e.rel, 128'(a_out), 128'(mon_e.a));
          endcase
        end
        sb.delete(q);
      end
    end
  end

  function automatic exp_t pass_entry(input int tag, input int base, input int k);
    exp_t e;
    int   t;
    e      = '0;
    e.tag  = tag;
    e.cyc  = base + k;
    e.rel  = k;
    e.clr  = (k == 1);
    e.busy = (k >= 1) && (k <= 3 * N);
    e.done = (k == PASS_LEN);
    if ((k >= 2) && (k <= 2 * N)) begin
      t = k - 2;
      for (int i = 0; i < N; i++) begin
        if ((t - i >= 0) && (t - i < N)) begin
          e.a[i*D +: D] = D'(am[i][t-i]);
          e.b[i*D +: D] = D'(bm[t-i][i]);
        end
      end
    end
    return e;
  endfunction

  function automatic exp_t idle_entry(input int tag, input int abs_cyc, input logic clr);
    exp_t e;
    e     = '0;
    e.tag = tag;
    e.cyc = abs_cyc;
    e.rel = -1;
    e.clr = clr;
    return e;
  endfunction

  task automatic push_hand_a(input int tag, input int base, input int k, input logic [W-1:0] a);
    exp_t e;
    e      = '0;
    e.tag  = tag;
    e.cyc  = base + k;
    e.rel  = k;
    e.kind = 2;
    e.a    = a;
    sb.push_back(e);
  endtask

  task automatic push_results(input int tag, input int abs_cyc);
    exp_t e;
    for (int idx = 0; idx < N * N; idx++) begin
      e      = '0;
      e.tag  = tag;
      e.cyc  = abs_cyc;
      e.kind = 1;
      e.idx  = idx;
      e.val  = cexp[idx / N][idx % N];
      sb.push_back(e);
    end
  endtask

  task automatic push_pass(input int tag, input int base, input int upto);
    for (int k = 1; k <= upto; k++) sb.push_back(pass_entry(tag, base, k));
    if (upto == PASS_LEN) push_results(tag, base + PASS_LEN);
  endtask

  task automatic applyStimulus(input int tag, input int upto, input bit hold, output int base);
    base  = cyc;
    start = 1'b1;
    push_pass(tag, base, upto);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic write_cell(input bit sel, input int r, input int c, input int v);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = IW'(r);
    wr_col  = IW'(c);
    wr_data = D'(v);
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) bm[r][c] = v;
    else     am[r][c] = v;
  endtask

  task automatic wait_until(input int abs_cyc);
    while (cyc < abs_cyc) @(negedge clk);
  endtask

  task automatic product_expect();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        cexp[i][j] = 0;
        for (int k = 0; k < N; k++) cexp[i][j] += am[i][k] * bm[k][j];
      end
  endtask

  task automatic load_identity_ramp();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_cell(1'b0, i, j, (i == j) ? 1 : 0);
        write_cell(1'b1, i, j, i * 4 + j + 1);
        cexp[i][j] = i * 4 + j + 1;
      end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int b;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = '0;
    start   = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = 0;
        bm[i][j] = 0;
      end

    repeat (3) @(negedge clk);
    sb.push_back(idle_entry(0, cyc + 1, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(idle_entry(0, cyc + 1, 1'b0));
    sb.push_back(idle_entry(0, cyc + 2, 1'b0));
    @(negedge clk);
    @(negedge clk);

    // Skew pattern pass with hand-computed edge values
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_cell(1'b0, i, j, 10 * i + j + 1);
        write_cell(1'b1, i, j, 10 * i + j + 1);
      end
    product_expect();
    push_hand_a(1, cyc, 2, 32'h0000_0001);
    push_hand_a(1, cyc, 5, 32'h1F16_0D04);
    push_hand_a(1, cyc, 8, 32'h2200_0000);
    applyStimulus(1, PASS_LEN, 1'b0, b);
    wait_until(b + PASS_LEN + 1);

    // Write and start while busy are both ignored
    applyStimulus(2, PASS_LEN, 1'b0, b);
    wait_until(b + 6);
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_data = 8'd99;
    start   = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    start = 1'b0;
    for (int k = PASS_LEN + 1; k <= PASS_LEN + 4; k++) sb.push_back(idle_entry(2, b + k, 1'b0));
    wait_until(b + PASS_LEN + 5);
    push_hand_a(3, cyc, 2, 32'h0000_0001);
    applyStimulus(3, PASS_LEN, 1'b0, b);
    wait_until(b + PASS_LEN + 1);

    // Identity A against ramp B
    load_identity_ramp();
    applyStimulus(4, PASS_LEN, 1'b0, b);
    wait_until(b + PASS_LEN + 1);

    // All-ones operands at full width
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        write_cell(1'b0, i, j, 255);
        write_cell(1'b1, i, j, 255);
        cexp[i][j] = 260100;
      end
    applyStimulus(5, PASS_LEN, 1'b0, b);
    wait_until(b + PASS_LEN + 1);

    // Reset mid-pass clears buffers and suppresses done
    applyStimulus(6, 7, 1'b0, b);
    wait_until(b + 7);
    reset = 1'b1;
    sb.push_back(idle_entry(6, b + 8, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    for (int k = 9; k <= 16; k++) sb.push_back(idle_entry(6, b + k, 1'b0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j]   = 0;
        bm[i][j]   = 0;
        cexp[i][j] = 0;
      end
    wait_until(b + 17);
    applyStimulus(7, PASS_LEN, 1'b0, b);
    wait_until(b + PASS_LEN + 1);

    // Back-to-back passes with start held high
    load_identity_ramp();
    applyStimulus(8, PASS_LEN, 1'b1, b);
    push_pass(8, b + 14, PASS_LEN);
    wait_until(b + 27);
    start = 1'b0;
    for (int k = 28; k <= 30; k++) sb.push_back(idle_entry(8, b + k, 1'b0));

    for (int n = 0; n < 50 && sb.size() > 0; n++) @(negedge clk);
    checkOutput(99, 9, 0, 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
